// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the fifo_mem write port
// between N valid/ready producers. Each grant lasts up to BURST_MAX beats
// (one beat when fifo_threshold is high). Nothing is written while the FIFO
// is full.
// Optional build macro FIFO_ARB_PRIO_EN: requester 0 always wins arbitration
// whenever it is valid. The other requesters stay round-robin.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic                 fifo_wr,
  output logic [W-1:0]         fifo_data_in,
  input  logic                 fifo_full,
  input  logic                 fifo_threshold,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  grant_reg, grant_next;
  logic [IW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]  beat_cnt_reg, beat_cnt_next;

  logic [IW-1:0]  sel;
  logic           sel_found;
  logic           granted_valid;
  logic           accept;
  logic [CW:0]    beat_sum;
  logic [CW:0]    limit;

  // Pick the first valid requester after the last one granted, wrapping at N.
  always_comb begin
    int idx;
    sel       = '0;
    sel_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (!sel_found && req_valid[idx]) begin
        sel       = IW'(idx);
        sel_found = 1'b1;
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req_valid[0]) begin
      sel       = '0;
      sel_found = 1'b1;
    end
`else
`endif
  end

  assign busy          = (state_reg == BURST);
  assign grant_id      = grant_reg;
  assign granted_valid = req_valid[grant_reg];
  // A beat is only ever written when the FIFO has room, so it cannot overflow.
  assign accept        = busy && granted_valid && !fifo_full;
  assign fifo_wr       = accept;
  assign fifo_data_in  = busy ? req_data[grant_reg*W +: W] : '0;

  // Only the granted requester sees ready, and only while the FIFO has room.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign req_ready[gi] = busy && (grant_reg == IW'(gi)) && !fifo_full;
    end
  endgenerate

  // Near-full FIFO shortens every burst to a single beat.
  assign limit    = fifo_threshold ? (CW+1)'(1) : (CW+1)'(BURST_MAX);
  assign beat_sum = {1'b0, beat_cnt_reg} + (CW+1)'(1);

  // Next-state logic: arbitrate in IDLE, count beats and decide exit in BURST.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next    = BURST;
          grant_next    = sel;
          rr_ptr_next   = sel;
          beat_cnt_next = '0;
        end
      end
      BURST: begin
        if (!granted_valid) begin
          // Producer ran dry: give the port back even if stalled on full.
          state_next = IDLE;
        end else if (accept) begin
          beat_cnt_next = beat_sum[CW-1:0];
          if (beat_sum >= limit) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers; reset leaves requester 0 as first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= IW'(N - 1);
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (N=4, W=8, BURST_MAX=4).
// Honours FIFO_ARB_PRIO_EN for the expected grant order.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr;
  logic [7:0]  fifo_data_in;
  logic        fifo_full;
  logic        fifo_threshold;
  logic [1:0]  grant_id;
  logic        busy;

  int checks;
  int errors;
  int ovf;

  fifo_wr_arbiter #(.N(4), .W(8), .BURST_MAX(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_wr        (fifo_wr),
    .fifo_data_in   (fifo_data_in),
    .fifo_full      (fifo_full),
    .fifo_threshold (fifo_threshold),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Any write while full would overflow fifo_mem.
  always @(posedge clk) begin
    if (fifo_wr && fifo_full) ovf <= ovf + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare all outputs; grant_id is meaningful only while busy.
  task automatic co(input string tag, input logic eb, input logic [1:0] eg,
                    input logic ew, input logic [3:0] er, input logic [7:0] ed);
    chk({tag, ".busy"},  32'(busy),         32'(eb));
    chk({tag, ".wr"},    32'(fifo_wr),      32'(ew));
    chk({tag, ".ready"}, 32'(req_ready),    32'(er));
    chk({tag, ".data"},  32'(fifo_data_in), 32'(ed));
    if (eb) chk({tag, ".grant"}, 32'(grant_id), 32'(eg));
    $display("%0t %s valid=%b full=%b thr=%b busy=%b grant=%0d wr=%b data=%02h",
             $time, tag, req_valid, fifo_full, fifo_threshold, busy, grant_id,
             fifo_wr, fifo_data_in);
  endtask

  // Apply one cycle of inputs right after the falling edge, settle, then check.
  task automatic drv(input logic [3:0] v, input logic [31:0] d,
                     input logic full, input logic thr);
    @(negedge clk);
    req_valid      = v;
    req_data       = d;
    fifo_full      = full;
    fifo_threshold = thr;
    #1;
  endtask

  // Hold reset with random inputs, check outputs idle, release with no requests.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n          = 1'b0;
    req_valid      = 4'($urandom);
    req_data       = $urandom;
    fifo_full      = 1'($urandom);
    fifo_threshold = 1'($urandom);
    #1;
    co(tag, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
    chk({tag, ".grant"}, 32'(grant_id), 32'd0);
    @(negedge clk);
    req_valid      = '0;
    req_data       = '0;
    fifo_full      = 1'b0;
    fifo_threshold = 1'b0;
    rst_n          = 1'b1;
  endtask

  function automatic logic [31:0] d1(input logic [7:0] x);
    return {16'h0000, x, 8'h00};
  endfunction

  function automatic logic [31:0] d2(input logic [7:0] x);
    return {8'h00, x, 16'h0000};
  endfunction

  initial begin
    logic [1:0] order [5];
    logic       eb;
    logic [1:0] eg;
    checks = 0;
    errors = 0;
    ovf    = 0;
    clk            = 1'b0;
    rst_n          = 1'b1;
    req_valid      = '0;
    req_data       = '0;
    fifo_full      = 1'b0;
    fifo_threshold = 1'b0;
    #2 rst_n = 1'b0;

    // Test 1: reset with random inputs, then requester 0 after one IDLE cycle.
    do_reset("t1rst_a");
    do_reset("t1rst_b");
    drv(4'b0001, 32'h0000_005A, 1'b0, 1'b0); co("t1s0", 0, 0, 0, 4'b0000, 8'h00);
    drv(4'b0000, 32'h0000_005A, 1'b0, 1'b0); co("t1s1", 1, 0, 0, 4'b0001, 8'h5A);

    // Test 2: requester 2 alone, six beats split 4 + 2.
    drv(4'b0100, d2(8'h11), 1'b0, 1'b0); co("t2s0", 0, 2, 0, 4'b0000, 8'h00);
    drv(4'b0100, d2(8'h11), 1'b0, 1'b0); co("t2s1", 1, 2, 1, 4'b0100, 8'h11);
    drv(4'b0100, d2(8'h12), 1'b0, 1'b0); co("t2s2", 1, 2, 1, 4'b0100, 8'h12);
    drv(4'b0100, d2(8'h13), 1'b0, 1'b0); co("t2s3", 1, 2, 1, 4'b0100, 8'h13);
    drv(4'b0100, d2(8'h14), 1'b0, 1'b0); co("t2s4", 1, 2, 1, 4'b0100, 8'h14);
    drv(4'b0100, d2(8'h15), 1'b0, 1'b0); co("t2s5", 0, 2, 0, 4'b0000, 8'h00);
    drv(4'b0100, d2(8'h15), 1'b0, 1'b0); co("t2s6", 1, 2, 1, 4'b0100, 8'h15);
    drv(4'b0100, d2(8'h16), 1'b0, 1'b0); co("t2s7", 1, 2, 1, 4'b0100, 8'h16);
    drv(4'b0000, 32'h0,     1'b0, 1'b0); co("t2s8", 1, 2, 0, 4'b0100, 8'h00);
    drv(4'b0000, 32'h0,     1'b0, 1'b0); co("t2s9", 0, 2, 0, 4'b0000, 8'h00);

    // Test 3: all requesters valid, four-beat bursts separated by one IDLE.
`ifdef FIFO_ARB_PRIO_EN
    order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    do_reset("t3rst");
    for (int s = 0; s < 25; s++) begin
      eb = (s % 5) != 0;
      eg = order[s / 5];
      drv(4'b1111, 32'hA3A2_A1A0, 1'b0, 1'b0);
      co($sformatf("t3s%0d", s), eb, eg, eb,
         eb ? (4'b0001 << eg) : 4'b0000,
         eb ? (8'hA0 + 8'(eg)) : 8'h00);
    end

    // Test 4: FIFO full for three cycles after beat 2 of requester 1.
    do_reset("t4rst");
    drv(4'b0010, d1(8'h21), 1'b0, 1'b0); co("t4s0", 0, 1, 0, 4'b0000, 8'h00);
    drv(4'b0010, d1(8'h21), 1'b0, 1'b0); co("t4s1", 1, 1, 1, 4'b0010, 8'h21);
    drv(4'b0010, d1(8'h22), 1'b0, 1'b0); co("t4s2", 1, 1, 1, 4'b0010, 8'h22);
    drv(4'b0010, d1(8'h23), 1'b1, 1'b0); co("t4s3", 1, 1, 0, 4'b0000, 8'h23);
    drv(4'b0010, d1(8'h23), 1'b1, 1'b0); co("t4s4", 1, 1, 0, 4'b0000, 8'h23);
    drv(4'b0010, d1(8'h23), 1'b1, 1'b0); co("t4s5", 1, 1, 0, 4'b0000, 8'h23);
    drv(4'b0010, d1(8'h23), 1'b0, 1'b0); co("t4s6", 1, 1, 1, 4'b0010, 8'h23);
    drv(4'b0010, d1(8'h24), 1'b0, 1'b0); co("t4s7", 1, 1, 1, 4'b0010, 8'h24);
    drv(4'b0010, d1(8'h25), 1'b0, 1'b0); co("t4s8", 0, 1, 0, 4'b0000, 8'h00);
    drv(4'b0010, d1(8'h25), 1'b0, 1'b0); co("t4s9", 1, 1, 1, 4'b0010, 8'h25);

    // Test 5: asynchronous reset in the middle of requester 1's burst.
    drv(4'b0010, d1(8'h26), 1'b0, 1'b0); co("t5pre", 1, 1, 1, 4'b0010, 8'h26);
    #2 rst_n = 1'b0;
    #1 co("t5async", 0, 0, 0, 4'b0000, 8'h00);
    chk("t5async.grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    drv(4'b1111, 32'hA3A2_A1A0, 1'b0, 1'b0); co("t5s0", 0, 0, 0, 4'b0000, 8'h00);
    drv(4'b1111, 32'hA3A2_A1A0, 1'b0, 1'b0); co("t5s1", 1, 0, 1, 4'b0001, 8'hA0);

    // Test 6: threshold forces single-beat bursts for requesters 0 and 3.
    do_reset("t6rst");
    for (int s = 0; s < 8; s++) begin
      eb = (s % 2) != 0;
`ifdef FIFO_ARB_PRIO_EN
      eg = 2'd0;
`else
      eg = ((s / 2) % 2 == 0) ? 2'd0 : 2'd3;
`endif
      drv(4'b1001, 32'hB300_00B0, 1'b0, 1'b1);
      co($sformatf("t6s%0d", s), eb, eg, eb,
         eb ? (4'b0001 << eg) : 4'b0000,
         eb ? ((eg == 2'd0) ? 8'hB0 : 8'hB3) : 8'h00);
    end

    @(negedge clk);
    chk("no_overflow", 32'(ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
